// File: rtl/convolve_accum.sv
// Accumulates KERNEL_TAPS signed 12.4 products per window, then rounds and saturates each sum to an 8-bit pixel.
// Optional build macro CONV_ABS_EN: emit the rounded magnitude of the sum (edge/gradient kernels).
module convolve_accum #(
  parameter int KERNEL_TAPS = 9,
  parameter int ACC_W       = 20
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [15:0]                    prod_in,
  input  logic                           prod_valid,
  output logic                           prod_ready,
  input  logic                           win_clear,
  output logic [7:0]                     pix_out,
  output logic                           pix_valid,
  input  logic                           pix_ready,
  output logic [$clog2(KERNEL_TAPS)-1:0] tap_cnt
);

  localparam int TW = $clog2(KERNEL_TAPS);
  localparam logic [TW-1:0] LAST_TAP = TW'(KERNEL_TAPS - 1);
  localparam logic signed [ACC_W+1:0] HALF_LSB = (ACC_W+2)'(8);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                    state_q, state_d;
  logic [TW-1:0]             tap_cnt_q, tap_cnt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [7:0]                pix_q, pix_d;
  logic                      pix_valid_q, pix_valid_d;
  logic signed [ACC_W-1:0]   prod_sext;
  logic signed [ACC_W-1:0]   fin;
  logic                      last_tap;
  logic                      accept;

  // Two guard bits keep both the +8 rounding and the negation of the most-negative sum exact.
  function automatic logic [7:0] round_sat(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W+1:0] ext;
    logic signed [ACC_W+1:0] rnd;
    ext = {{2{sum[ACC_W-1]}}, sum};
`ifdef CONV_ABS_EN
    if (ext[ACC_W+1]) ext = -ext;
`endif
    rnd = (ext + HALF_LSB) >>> 4;
    if (rnd[ACC_W+1])
      return 8'd0;
    else if (|rnd[ACC_W:8])
      return 8'hFF;
    else
      return rnd[7:0];
  endfunction

  assign prod_sext = {{(ACC_W-16){prod_in[15]}}, prod_in};
  assign fin       = acc_q + prod_sext;
  assign last_tap  = (tap_cnt_q == LAST_TAP);
  assign accept    = prod_valid && prod_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tap_cnt_q   <= '0;
      acc_q       <= '0;
      pix_q       <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_cnt_q   <= tap_cnt_d;
      acc_q       <= acc_d;
      pix_q       <= pix_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  // Next state: a clear drops the window; the last tap loads the output register in the same edge a held pixel drains.
  always_comb begin
    state_d     = state_q;
    tap_cnt_d   = tap_cnt_q;
    acc_d       = acc_q;
    pix_d       = pix_q;
    pix_valid_d = pix_valid_q && !pix_ready;
    if (win_clear) begin
      state_d   = IDLE;
      tap_cnt_d = '0;
      acc_d     = '0;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          acc_d     = prod_sext;
          tap_cnt_d = TW'(1);
          state_d   = ACCUM;
        end
        ACCUM: begin
          if (last_tap) begin
            acc_d       = '0;
            tap_cnt_d   = '0;
            state_d     = IDLE;
            pix_d       = round_sat(fin);
            pix_valid_d = 1'b1;
          end else begin
            acc_d     = fin;
            tap_cnt_d = tap_cnt_q + TW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Only the closing tap waits on an unconsumed pixel; earlier taps of the next window flow freely.
  always_comb begin
    prod_ready = !win_clear && !(last_tap && pix_valid_q && !pix_ready);
  end

  assign pix_out   = pix_q;
  assign pix_valid = pix_valid_q;
  assign tap_cnt   = tap_cnt_q;

endmodule

// File: tb/tb_convolve_accum.sv
// Scoreboard bench for convolve_accum: directed scenarios plus randomized traffic against a window-sum reference model.
module tb_convolve_accum;

  localparam int TAPS = 9;
  localparam int TW   = $clog2(TAPS);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   prod_in = '0;
  logic          prod_valid = 1'b0;
  logic          prod_ready;
  logic          win_clear = 1'b0;
  logic [7:0]    pix_out;
  logic          pix_valid;
  logic          pix_ready = 1'b1;
  logic [TW-1:0] tap_cnt;

  int checks = 0;
  int errors = 0;
  int win[$];
  int exp_q[$];
  int last_pix = -1;

  convolve_accum #(.KERNEL_TAPS(TAPS), .ACC_W(20)) dut (
    .clk(clk), .reset(reset), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(prod_ready), .win_clear(win_clear), .pix_out(pix_out),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .tap_cnt(tap_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer sum of the window, round half up in 1/16 units, then clamp (or magnitude).
  function automatic int ref_pix(input int s);
    int r;
`ifdef CONV_ABS_EN
    r = ((s < 0 ? -s : s) + 8) / 16;
    return (r > 255) ? 255 : r;
`else
    r = s + 8;
    if (r < 0) return 0;
    r = r / 16;
    return (r > 255) ? 255 : r;
`endif
  endfunction

  // Monitor: sample between edges, predict what the coming edge does.
  always @(negedge clk) begin
    if (reset) begin
      win.delete();
      exp_q.delete();
    end else begin
      int  s;
      bit  pending;
      bit  exp_ready;
      pending   = (exp_q.size() > 0);
      exp_ready = !win_clear && !(win.size() == TAPS-1 && pending && !pix_ready);
      chk("prod_ready", int'(prod_ready), int'(exp_ready));
      chk("tap_cnt", int'(tap_cnt), win.size());
      chk("pix_valid", int'(pix_valid), int'(pending));
      if (pix_valid && pending) begin
        chk("pix_out", int'(pix_out), exp_q[0]);
        if (pix_ready) last_pix = exp_q.pop_front();
      end
      if (win_clear) begin
        win.delete();
      end else if (prod_valid && exp_ready) begin
        win.push_back(int'($signed(prod_in)));
        if (win.size() == TAPS) begin
          s = 0;
          foreach (win[i]) s += win[i];
          exp_q.push_back(ref_pix(s));
          win.delete();
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic [15:0] v);
    int n;
    bit took;
    n = 0;
    took = 1'b0;
    prod_valid = 1'b1;
    prod_in = v;
    while (!took && n < 200) begin
      @(negedge clk);
      took = prod_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!took) chk("beat_timeout", 0, 1);
    prod_valid = 1'b0;
    prod_in = 16'($urandom);
  endtask

  task automatic window(input logic [15:0] first, input logic [15:0] rest);
    beat(first);
    for (int i = 1; i < TAPS; i++) beat(rest);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_tap_cnt", int'(tap_cnt), 0);
    chk("rst_pix_out", int'(pix_out), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick(1);

    // Nominal window and saturation in both directions
    last_pix = -1;
    window(16'h0100, 16'h0100);
    tick(2);
    chk("t1_144", last_pix, 144);
    window(16'h0FF0, 16'h0FF0);
    tick(2);
    chk("t2_sat_hi", last_pix, 255);
    window(16'hFF00, 16'hFF00);
    tick(2);
`ifdef CONV_ABS_EN
    chk("t2_neg", last_pix, 144);
`else
    chk("t2_neg", last_pix, 0);
`endif

    // Rounding boundaries
    window(16'h0018, 16'h0000);
    tick(2);
    chk("t3_1p5", last_pix, 2);
    window(16'h0017, 16'h0000);
    tick(2);
    chk("t3_1p4375", last_pix, 1);
    window(16'hFFF8, 16'h0000);
    tick(2);
`ifdef CONV_ABS_EN
    chk("t3_neg_half", last_pix, 1);
`else
    chk("t3_neg_half", last_pix, 0);
`endif

    // Back-to-back windows against a stalled consumer
    pix_ready = 1'b0;
    window(16'h0100, 16'h0100);
    fork
      window(16'h0010, 16'h0010);
      begin
        tick(20);
        pix_ready = 1'b1;
      end
    join
    tick(3);
    chk("t4_second", last_pix, 9);

    // Window clear discards the partial sum; a beat in the clear cycle is dropped
    for (int i = 0; i < 4; i++) beat(16'h0100);
    win_clear = 1'b1;
    prod_valid = 1'b1;
    prod_in = 16'h7FFF;
    tick(1);
    win_clear = 1'b0;
    prod_valid = 1'b0;
    window(16'h0010, 16'h0010);
    tick(2);
    chk("t5_clear", last_pix, 9);

    // Asynchronous reset mid-window with a held pixel
    pix_ready = 1'b0;
    window(16'h0100, 16'h0100);
    for (int i = 0; i < 5; i++) beat(16'h0100);
    #2 reset = 1'b1;
    #1;
    chk("t6_pix_valid", int'(pix_valid), 0);
    chk("t6_tap_cnt", int'(tap_cnt), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    pix_ready = 1'b1;
    last_pix = -1;
    window(16'h0100, 16'h0100);
    tick(2);
    chk("t6_after", last_pix, 144);

    // Randomized traffic with stalls and occasional clears
    for (int i = 0; i < 1500; i++) begin
      prod_valid = ($urandom_range(3) != 0);
      prod_in    = 16'($urandom);
      pix_ready  = ($urandom_range(2) != 0);
      win_clear  = ($urandom_range(49) == 0);
      tick(1);
    end
    prod_valid = 1'b0;
    win_clear  = 1'b0;
    pix_ready  = 1'b1;
    tick(5);
    chk("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
